// File: rtl/edge_pkg.sv
// Shared types and helpers for the multi-channel edge debouncer.
package edge_pkg;

  // Which debounced transitions raise an event on a channel.
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_t;

  // True when a transition to new_level is one the mode cares about.
  function automatic logic edge_match(input edge_mode_t m, input logic new_level);
    logic hit;
    hit = 1'b0;
    case (m)
      EDGE_RISE: hit = new_level;
      EDGE_FALL: hit = ~new_level;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One debouncer channel: synchroniser, stability counter, edge pulses,
// and a sticky pending flag.
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  edge_mode_t mode,
  input  logic       clr,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       evt,
  output logic       pending
);

  // Count value on which a still-differing input is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   level_reg;
  logic                   rise_reg;
  logic                   fall_reg;
  logic                   evt_reg;
  logic                   pending_reg;
  logic                   sync;

  assign sync = sync_reg[SYNC_STAGES-1];

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in};
    end
  end

  // Accept the synchronised value once it has differed for the full window;
  // any return to the current level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      evt_reg   <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      evt_reg  <= 1'b0;
      if (sync != level_reg) begin
        if (cnt_reg == CNT_MAX) begin
          level_reg <= sync;
          cnt_reg   <= '0;
          rise_reg  <= sync;
          fall_reg  <= ~sync;
          evt_reg   <= edge_match(mode, sync);
        end else if (cnt_reg < CNT_MAX) begin
          // Guarded so the count can never wrap.
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  // Sticky event flag; a new event beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg <= 1'b0;
    end else if (evt_reg) begin
      pending_reg <= 1'b1;
    end else if (clr) begin
      pending_reg <= 1'b0;
    end
  end

  assign level   = level_reg;
  assign rise    = rise_reg;
  assign fall    = fall_reg;
  assign evt     = evt_reg;
  assign pending = pending_reg;

endmodule

// File: rtl/multi_edge_debouncer.sv
// N_CH independent debounced edge detectors with a combined interrupt.
module multi_edge_debouncer
  import edge_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   in,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   level,
  output logic [N_CH-1:0]   rise,
  output logic [N_CH-1:0]   fall,
  output logic [N_CH-1:0]   evt,
  output logic [N_CH-1:0]   pending,
  output logic              irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Refuse to build with parameters the channel logic cannot support.
  if (N_CH < 1 || N_CH > 32 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_error
    $error("multi_edge_debouncer: illegal parameters N_CH=%0d SYNC_STAGES=%0d DEBOUNCE_CYCLES=%0d",
           N_CH, SYNC_STAGES, DEBOUNCE_CYCLES);
  end

  logic irq_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .in     (in[gi]),
      .mode   (edge_mode_t'(mode[2*gi +: 2])),
      .clr    (clr[gi]),
      .level  (level[gi]),
      .rise   (rise[gi]),
      .fall   (fall[gi]),
      .evt    (evt[gi]),
      .pending(pending[gi])
    );
  end

  // Interrupt follows the OR of all pending flags one clock later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= |pending;
    end
  end

  assign irq = irq_reg;

endmodule

// File: tb/tb_multi_edge_debouncer.sv
// Directed scoreboard bench for multi_edge_debouncer (N_CH=4, 2 sync, 4 debounce).
module tb_multi_edge_debouncer;
  import edge_pkg::*;

  localparam int S_LEVEL = 0, S_RISE = 1, S_FALL = 2, S_EVT = 3, S_PEND = 4, S_IRQ = 5;

  typedef struct {
    int         cyc;
    string      tag;
    int         sig;
    logic [3:0] mask;
    logic [3:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic [7:0] mode;
  logic [3:0] clr;
  logic [3:0] level, rise, fall, evt, pending;
  logic       irq;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  multi_edge_debouncer #(
    .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .in(din), .mode(mode), .clr(clr),
    .level(level), .rise(rise), .fall(fall), .evt(evt),
    .pending(pending), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [3:0] observe(input int sig);
    case (sig)
      S_LEVEL: return level;
      S_RISE:  return rise;
      S_FALL:  return fall;
      S_EVT:   return evt;
      S_PEND:  return pending;
      default: return {3'b000, irq};
    endcase
  endfunction

  // Queue an expectation for every cycle in [from, to].
  task automatic expect_win(input string tag, input int sig, input logic [3:0] mask,
                            input logic [3:0] val, input int from, input int to);
    for (int c = from; c <= to; c++) sb.push_back('{c, tag, sig, mask, val});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    logic [20:0] o;
    o = {level, rise, fall, evt, pending, irq};
    checks++;
    assert (o === 21'd0) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, o, 21'd0);
    end
  endtask

  // Pop and compare every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [3:0] o;
        o = observe(sb[i].sig) & sb[i].mask;
        checks++;
        assert (o === (sb[i].val & sb[i].mask)) else begin
          errors++;
          $error("FAIL %s cyc %0d observed %h expected %h", sb[i].tag, cyc, o,
                 sb[i].val & sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1;
    din   = 4'h0;
    clr   = 4'h0;
    // ch0 RISE, ch1 BOTH, ch2 FALL, ch3 BOTH
    mode  = {EDGE_BOTH, EDGE_FALL, EDGE_BOTH, EDGE_RISE};
    step(3);
    check_all_zero("reset_state");
    reset = 1'b0;
    step(3);

    // A: single rising input on ch0, 6-edge latency
    k = cyc;
    din[0] = 1'b1;
    expect_win("A_level_pre", S_LEVEL, 4'h1, 4'h0, k + 1, k + 5);
    expect_win("A_level",     S_LEVEL, 4'h1, 4'h1, k + 6, k + 9);
    expect_win("A_rise_pre",  S_RISE,  4'h1, 4'h0, k + 1, k + 5);
    expect_win("A_rise",      S_RISE,  4'h1, 4'h1, k + 6, k + 6);
    expect_win("A_rise_post", S_RISE,  4'h1, 4'h0, k + 7, k + 9);
    expect_win("A_fall",      S_FALL,  4'h1, 4'h0, k + 1, k + 12);
    expect_win("A_evt",       S_EVT,   4'h1, 4'h1, k + 6, k + 6);
    expect_win("A_evt_post",  S_EVT,   4'h1, 4'h0, k + 7, k + 7);
    expect_win("A_pend_pre",  S_PEND,  4'h1, 4'h0, k + 1, k + 6);
    expect_win("A_pend",      S_PEND,  4'h1, 4'h1, k + 7, k + 10);
    expect_win("A_pend_clr",  S_PEND,  4'h1, 4'h0, k + 11, k + 12);
    expect_win("A_irq_pre",   S_IRQ,   4'h1, 4'h0, k + 1, k + 7);
    expect_win("A_irq",       S_IRQ,   4'h1, 4'h1, k + 8, k + 11);
    expect_win("A_irq_clr",   S_IRQ,   4'h1, 4'h0, k + 12, k + 12);
    step(10);
    clr = 4'h1;
    step(1);
    clr = 4'h0;
    step(3);

    // B: 3-clock glitch on ch1 must be ignored
    k = cyc;
    din[1] = 1'b1;
    expect_win("B_level", S_LEVEL, 4'h2, 4'h0, k + 1, k + 15);
    expect_win("B_rise",  S_RISE,  4'h2, 4'h0, k + 1, k + 15);
    expect_win("B_fall",  S_FALL,  4'h2, 4'h0, k + 1, k + 15);
    expect_win("B_evt",   S_EVT,   4'h2, 4'h0, k + 1, k + 15);
    step(3);
    din[1] = 1'b0;
    step(14);

    // C: ch2 in FALL mode, rise then fall
    k = cyc;
    din[2] = 1'b1;
    expect_win("C_level_pre",  S_LEVEL, 4'h4, 4'h0, k + 1, k + 5);
    expect_win("C_level_hi",   S_LEVEL, 4'h4, 4'h4, k + 6, k + 15);
    expect_win("C_level_lo",   S_LEVEL, 4'h4, 4'h0, k + 16, k + 20);
    expect_win("C_rise",       S_RISE,  4'h4, 4'h4, k + 6, k + 6);
    expect_win("C_rise_post",  S_RISE,  4'h4, 4'h0, k + 7, k + 7);
    expect_win("C_evt_quiet",  S_EVT,   4'h4, 4'h0, k + 1, k + 15);
    expect_win("C_evt",        S_EVT,   4'h4, 4'h4, k + 16, k + 16);
    expect_win("C_evt_post",   S_EVT,   4'h4, 4'h0, k + 17, k + 20);
    expect_win("C_fall_pre",   S_FALL,  4'h4, 4'h0, k + 15, k + 15);
    expect_win("C_fall",       S_FALL,  4'h4, 4'h4, k + 16, k + 16);
    expect_win("C_fall_post",  S_FALL,  4'h4, 4'h0, k + 17, k + 17);
    expect_win("C_pend_pre",   S_PEND,  4'h4, 4'h0, k + 1, k + 16);
    expect_win("C_pend",       S_PEND,  4'h4, 4'h4, k + 17, k + 20);
    expect_win("C_pend_clr",   S_PEND,  4'h4, 4'h0, k + 21, k + 21);
    expect_win("C_irq_pre",    S_IRQ,   4'h1, 4'h0, k + 1, k + 17);
    expect_win("C_irq",        S_IRQ,   4'h1, 4'h1, k + 18, k + 21);
    expect_win("C_irq_clr",    S_IRQ,   4'h1, 4'h0, k + 22, k + 22);
    step(10);
    din[2] = 1'b0;
    step(10);
    clr = 4'h4;
    step(1);
    clr = 4'h0;
    step(3);

    // D: clear coincident with the event cycle on ch3 loses to the set
    k = cyc;
    din[3] = 1'b1;
    expect_win("D_evt",       S_EVT,  4'h8, 4'h8, k + 6, k + 6);
    expect_win("D_pend_pre",  S_PEND, 4'h8, 4'h0, k + 1, k + 6);
    expect_win("D_pend",      S_PEND, 4'h8, 4'h8, k + 7, k + 10);
    expect_win("D_pend_clr",  S_PEND, 4'h8, 4'h0, k + 11, k + 11);
    expect_win("D_irq",       S_IRQ,  4'h1, 4'h1, k + 8, k + 11);
    expect_win("D_irq_clr",   S_IRQ,  4'h1, 4'h0, k + 12, k + 12);
    step(6);
    clr = 4'h8;
    step(1);
    clr = 4'h0;
    step(3);
    clr = 4'h8;
    step(1);
    clr = 4'h0;
    step(3);

    // E: all inputs high through reset, one rise per channel after release
    din   = 4'hF;
    reset = 1'b1;
    #1;
    check_all_zero("E_reset_async");
    step(3);
    reset = 1'b0;
    k = cyc;
    expect_win("E_rise_pre",  S_RISE,  4'hF, 4'h0, k + 1, k + 5);
    expect_win("E_rise",      S_RISE,  4'hF, 4'hF, k + 6, k + 6);
    expect_win("E_rise_post", S_RISE,  4'hF, 4'h0, k + 7, k + 7);
    expect_win("E_level_pre", S_LEVEL, 4'hF, 4'h0, k + 5, k + 5);
    expect_win("E_level",     S_LEVEL, 4'hF, 4'hF, k + 6, k + 8);
    expect_win("E_evt",       S_EVT,   4'hF, 4'hB, k + 6, k + 6);
    expect_win("E_pend",      S_PEND,  4'hF, 4'hB, k + 7, k + 7);
    expect_win("E_irq",       S_IRQ,   4'h1, 4'h1, k + 8, k + 8);
    step(10);
    clr = 4'hF;
    step(1);
    clr = 4'h0;
    din = 4'h0;
    step(12);
    clr = 4'hF;
    step(1);
    clr = 4'h0;
    step(3);

    // F: reset two clocks into a debounce discards the partial count
    k = cyc;
    din[0] = 1'b1;
    step(4);
    reset = 1'b1;
    #1;
    check_all_zero("F_reset_mid");
    step(2);
    reset = 1'b0;
    k = cyc;
    expect_win("F_rise_pre",  S_RISE,  4'h1, 4'h0, k + 1, k + 5);
    expect_win("F_rise",      S_RISE,  4'h1, 4'h1, k + 6, k + 6);
    expect_win("F_level_pre", S_LEVEL, 4'h1, 4'h0, k + 1, k + 5);
    expect_win("F_level",     S_LEVEL, 4'h1, 4'h1, k + 6, k + 7);
    step(10);

    // Anything still queued was never reached.
    while (sb.size() > 0) begin
      checks++;
      assert (sb[0].cyc >= cyc) else begin
        errors++;
        $error("FAIL %s stale expectation cyc %0d observed none expected %h",
               sb[0].tag, sb[0].cyc, sb[0].val);
      end
      void'(sb.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_edge_debouncer.md
MULTI_EDGE_DEBOUNCER -- requirements
Module: multi_edge_debouncer

Interface
REQ-001 Parameters SHALL be: N_CH, default 4, channel count (1..32); SYNC_STAGES, default 2, synchroniser depth (>=2); DEBOUNCE_CYCLES, default 4, stability window in clocks (>=1); CNT_W = $clog2(DEBOUNCE_CYCLES+1), derived.
REQ-002 Port clk, input, 1, single clock for all logic.
REQ-003 Port reset, input, 1, asynchronous active-high reset.
REQ-004 Port in, input, N_CH, raw asynchronous inputs, one per channel.
REQ-005 Port mode, input, 2*N_CH, per-channel edge_mode_t (bits [2c+1:2c] for channel c).
REQ-006 Port clr, input, N_CH, per-channel clear for the pending flag.
REQ-007 Port level, output, N_CH, debounced level.
REQ-008 Port rise / fall, output, N_CH each, one-cycle pulse on a debounced 0->1 / 1->0 transition.
REQ-009 Port evt, output, N_CH, one-cycle pulse when the transition matches mode.
REQ-010 Port pending, output, N_CH, sticky event flag; irq, output, 1, OR of pending.

Function
REQ-011 Each in[c] SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is sync[c].
REQ-012 Per channel, while sync != level, a counter SHALL increment each clock; when sync == level, it SHALL clear to 0 that clock.
REQ-013 On the clock where the counter equals DEBOUNCE_CYCLES-1 and sync != level, level SHALL take sync and the counter SHALL clear.
REQ-014 Total latency, from a stable input change to level update, SHALL be SYNC_STAGES+DEBOUNCE_CYCLES clock edges; with DEBOUNCE_CYCLES=1, level follows sync one edge later.
REQ-015 A glitch on sync shorter than DEBOUNCE_CYCLES clocks SHALL NOT change level, nor pulse rise, fall or evt.
REQ-016 rise, fall and evt SHALL be registered and assert in the same cycle level first shows its new value, for exactly one cycle.
REQ-017 evt[c] SHALL be: EDGE_OFF=0; EDGE_RISE=rise[c]; EDGE_FALL=fall[c]; EDGE_BOTH=rise[c]|fall[c].
REQ-018 mode SHALL be sampled on the update clock; a mode change takes effect at the next transition, with no retroactive pulse.
REQ-019 pending[c] SHALL set on the clock after evt[c], and clear on the clock after clr[c]; if set and clear coincide, set SHALL win.
REQ-020 irq SHALL be registered: irq = |pending, one cycle after pending.
REQ-021 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be reported.
REQ-022 The counter SHALL saturate, never wrap, within CNT_W bits.

Reset
REQ-023 Reset SHALL clear the synchroniser flops, counters, level, rise, fall, evt, pending and irq to 0, asynchronously.
REQ-024 Reset SHALL release synchronously with clk. An input held high through reset SHALL produce one rise (and evt if the mode matches) SYNC_STAGES+DEBOUNCE_CYCLES edges after release.
REQ-025 Reset mid-debounce SHALL discard the partial count; no pulse SHALL be emitted for the interrupted transition.

Structure
REQ-026 Package edge_pkg SHALL hold typedef enum logic[1:0] edge_mode_t {EDGE_OFF=0, EDGE_RISE=1, EDGE_FALL=2, EDGE_BOTH=3}.
REQ-027 Per-channel logic SHALL be a sub-module edge_channel (sync, debounce, edge, pending), instantiated N_CH times by generate; the top holds only the irq reduction.
REQ-028 Illegal parameters (SYNC_STAGES<2, DEBOUNCE_CYCLES<1, N_CH outside 1..32) SHALL stop elaboration with $error.

Verification (N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-029 in[0] 0->1, held -> level[0]=1 and rise[0]=1 for one cycle, exactly 6 edges after the change; fall[0]=0.
REQ-030 in[1] high for 3 clocks, then low -> level[1], rise[1] and evt[1] stay 0 throughout.
REQ-031 mode[2]=EDGE_FALL, in[2] 0->1->0 (each held 10 clocks) -> evt[2] pulses only on the fall; pending[2]=1 next cycle, irq=1 one cycle later; clr[2] -> pending[2]=0.
REQ-032 clr[3] asserted on the same clock that evt[3] pulses (mode EDGE_BOTH) -> pending[3]=1.
REQ-033 in=4'hF held through reset, then release -> rise=4'hF for one cycle, 6 edges after release.
REQ-034 Reset asserted 2 clocks into a debounce on in[0] -> all outputs 0 immediately; no rise[0] until a fresh 6-edge stable period completes after release.
